instruction_fetch: RTL

- Front pipeline stage, directly upstream of instruction decode.
- Generates the fetch PC and requests 24-bit instructions from instruction memory over a req/ack handshake.
- Buffers returned words, with their PCs, in a small prefetch FIFO.
- Presents the FIFO head to decode, honours decode stall, and flushes and redirects on a taken branch.

---
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master) and memory (slave).
interface instruction_fetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 24
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Front-end fetch stage: PC generation, one-outstanding imem request, prefetch FIFO to decode,
// and branch flush/redirect with a DRAIN state that swallows the abandoned in-flight word.
module instruction_fetch #(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 24,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instruction,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic [ADDR_W-1:0]   fetch_pc
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_run_en;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  w_fetch_pc_next;
    logic [ADDR_W-1:0]  r_drain_addr;
    logic [ADDR_W-1:0]  w_drain_addr_next;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic [PTR_W-1:0]   w_wr_ptr_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [INSTR_W-1:0] r_instr_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_pc_mem    [FIFO_DEPTH];
    logic [INSTR_W-1:0] r_head_instr;
    logic [ADDR_W-1:0]  r_head_pc;
    logic [INSTR_W-1:0] w_head_instr_next;
    logic [ADDR_W-1:0]  w_head_pc_next;
    logic               w_req;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_ack;
    logic               w_push;
    logic               w_pop;

    // Next-state, handshake and FIFO bookkeeping
    always_comb begin
        w_req             = 1'b0;
        w_addr            = r_fetch_pc;
        w_state_next      = r_state;
        w_drain_addr_next = r_drain_addr;
        w_fetch_pc_next   = r_fetch_pc;

        // r_run_en keeps the request low until the first cycle after reset is released
        if (r_run_en) begin
            case (r_state)
                ST_RUN:   w_req = (r_count < DEPTH_C);
                ST_DRAIN: w_req = 1'b1;
                default:  w_req = 1'b0;
            endcase
        end
        if (r_state == ST_DRAIN) begin
            w_addr = r_drain_addr;
        end

        w_ack  = w_req & imem.imem_ack;
        w_push = w_ack & (r_state == ST_RUN) & ~branch_taken;
        w_pop  = (r_count != '0) & ~stall & ~branch_taken;

        case (r_state)
            ST_RUN: begin
                if (branch_taken && w_req && !imem.imem_ack) begin
                    w_state_next      = ST_DRAIN;
                    w_drain_addr_next = w_addr;
                end
            end
            ST_DRAIN: begin
                if (w_ack) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase

        if (branch_taken) begin
            w_fetch_pc_next = branch_target;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + ADDR_W'(1);
        end

        w_wr_ptr_next = r_wr_ptr + PTR_W'(w_push);
        w_rd_ptr_next = branch_taken ? r_wr_ptr : (r_rd_ptr + PTR_W'(w_pop));

        w_count_next = r_count;
        if (branch_taken) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end

        // Head registers track the entry that will sit at the read pointer; a word pushed into
        // an otherwise empty FIFO is bypassed straight from the registered write.
        w_head_instr_next = r_head_instr;
        w_head_pc_next    = r_head_pc;
        if (w_count_next != '0) begin
            if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
                w_head_instr_next = imem.imem_data;
                w_head_pc_next    = r_fetch_pc;
            end else begin
                w_head_instr_next = r_instr_mem[w_rd_ptr_next];
                w_head_pc_next    = r_pc_mem[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_run_en     <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_instr <= '0;
            r_head_pc    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_run_en     <= 1'b1;
            r_fetch_pc   <= w_fetch_pc_next;
            r_drain_addr <= w_drain_addr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_wr_ptr     <= w_wr_ptr_next;
            r_count      <= w_count_next;
            r_head_instr <= w_head_instr_next;
            r_head_pc    <= w_head_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_instr_mem[r_wr_ptr] <= imem.imem_data;
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;
    assign instr_valid    = (r_count != '0);
    assign instruction    = r_head_instr;
    assign instr_pc       = r_head_pc;
    assign fetch_pc       = r_fetch_pc;

endmodule
